// File: rtl/inst_enc.sv
// RV32I instruction encoder feeding a DEPTH-entry FIFO of {word, imem address, error flag}.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module inst_enc #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                in_type,
   input  logic [3:0]                in_alu_op,
   input  logic                      in_mem_sign,
   input  logic [4:0]                in_rd,
   input  logic [4:0]                in_rs1,
   input  logic [4:0]                in_rs2,
   input  logic [31:0]               in_imm,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_inst,
   output logic [31:0]               out_addr,
   output logic                      out_err,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [3:0] INST_ECALL      = 4'd0;
   localparam logic [3:0] INST_IMM        = 4'd1;
   localparam logic [3:0] INST_REG        = 4'd2;
   localparam logic [3:0] INST_LOAD_BYTE  = 4'd3;
   localparam logic [3:0] INST_LOAD_HALF  = 4'd4;
   localparam logic [3:0] INST_LOAD_WORD  = 4'd5;
   localparam logic [3:0] INST_STORE_BYTE = 4'd6;
   localparam logic [3:0] INST_STORE_HALF = 4'd7;
   localparam logic [3:0] INST_STORE      = 4'd8;
   localparam logic [3:0] INST_UPP        = 4'd9;
   localparam logic [3:0] INST_JUMP       = 4'd10;

   localparam logic [6:0] OPCODE_CALC_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_CALC_REG = 7'b0110011;
   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;

`ifdef ENC_RANGE_CHECK_EN
   localparam logic RANGE_CHK = 1'b1;
`else
   localparam logic RANGE_CHK = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        err;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [31:0]     addr_cnt;
   logic [31:0]     enc_inst;
   logic            enc_err, rng_err, i_bad;
   logic [2:0]      f3;
   logic [1:0]      size;
   logic            push, pop;

   assign f3    = in_alu_op[2:0];
   // I/S immediates are 12-bit signed: bits 31..11 must all match the sign.
   assign i_bad = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));

   always_comb begin
      enc_inst = 32'h0000_0013;
      enc_err  = 1'b0;
      rng_err  = 1'b0;
      size     = 2'b10;
      case (in_type)
         INST_ECALL: enc_inst = 32'h0000_0073;
         INST_IMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               enc_inst = {1'b0, in_alu_op[3] & f3[2], 5'b0, in_imm[4:0], in_rs1, f3, in_rd,
                           OPCODE_CALC_IMM};
               rng_err  = |in_imm[31:5];
            end else begin
               enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, OPCODE_CALC_IMM};
               rng_err  = i_bad;
            end
         end
         INST_REG:
            enc_inst = {1'b0, in_alu_op[3], 5'b0, in_rs2, in_rs1, f3, in_rd, OPCODE_CALC_REG};
         INST_LOAD_BYTE, INST_LOAD_HALF, INST_LOAD_WORD: begin
            size     = (in_type == INST_LOAD_BYTE) ? 2'b00 :
                       (in_type == INST_LOAD_HALF) ? 2'b01 : 2'b10;
            // No LWU in RV32I: flag it and fall back to LW.
            enc_inst = {in_imm[11:0], in_rs1, ~in_mem_sign & ~size[1], size, in_rd, OPCODE_LOAD};
            enc_err  = size[1] & ~in_mem_sign;
            rng_err  = i_bad;
         end
         INST_STORE_BYTE, INST_STORE_HALF, INST_STORE: begin
            size     = (in_type == INST_STORE_BYTE) ? 2'b00 :
                       (in_type == INST_STORE_HALF) ? 2'b01 : 2'b10;
            enc_inst = {in_imm[11:5], in_rs2, in_rs1, 1'b0, size, in_imm[4:0], OPCODE_STORE};
            rng_err  = i_bad;
         end
         INST_UPP: begin
            enc_inst = {in_imm[31:12], in_rd, OPCODE_LUI};
            rng_err  = |in_imm[11:0];
         end
         INST_JUMP: begin
            enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPCODE_JALR};
            rng_err  = i_bad;
         end
         default: enc_err = 1'b1;
      endcase
      enc_err = enc_err | (RANGE_CHK & rng_err);
   end

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   assign out_inst  = mem[rd_ptr].inst;
   assign out_addr  = mem[rd_ptr].addr;
   assign out_err   = mem[rd_ptr].err;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         addr_cnt <= BASE_ADDR;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '{inst: 32'h0, addr: BASE_ADDR, err: 1'b0};
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         addr_cnt <= BASE_ADDR;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{inst: enc_inst, addr: addr_cnt, err: enc_err};
            wr_ptr      <= wr_ptr + 1'b1;
            addr_cnt    <= addr_cnt + 32'd4;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_enc.sv
// Directed bench for inst_enc: table of single-instruction encodings plus FIFO/flush/reset sequences.
module tb_inst_enc;
   logic        clock = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, in_mem_sign;
   logic [3:0]  in_type, in_alu_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm, out_inst, out_addr;
   logic        out_valid, out_ready, out_err;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_addr;

`ifdef ENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   inst_enc #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_alu_op(in_alu_op), .in_mem_sign(in_mem_sign), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
      .count(count));

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [3:0]  typ;
      logic [3:0]  alu;
      logic        sgn;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] t, input logic [3:0] a, input logic s,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
      in_type = t; in_alu_op = a; in_mem_sign = s;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   initial begin
      vecs[0]  = '{"addi",      4'd1, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093, 1'b0};
      vecs[1]  = '{"sub",       4'd2, 4'b1000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3, 1'b0};
      vecs[2]  = '{"sw",        4'd8, 4'b0000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 1'b0};
      vecs[3]  = '{"srai",      4'd1, 4'b1101, 1'b0, 5'd4, 5'd4, 5'd0, 32'd3,         32'h4032_5213, 1'b0};
      vecs[4]  = '{"lui",       4'd9, 4'b0000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
      vecs[5]  = '{"lbu",       4'd3, 4'b0000, 1'b0, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'hFFF3_C303, 1'b0};
      vecs[6]  = '{"lwu_err",   4'd5, 4'b0000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4,         32'h0041_2083, 1'b1};
      vecs[7]  = '{"ecall",     4'd0, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0,         32'h0000_0073, 1'b0};
      vecs[8]  = '{"undef",     4'd15,4'b0000, 1'b0, 5'd9, 5'd9, 5'd9, 32'd77,        32'h0000_0013, 1'b1};
      vecs[9]  = '{"jalr",      4'd10,4'b0000, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0,         32'h0002_80E7, 1'b0};
      vecs[10] = '{"slli",      4'd1, 4'b0001, 1'b0, 5'd2, 5'd3, 5'd0, 32'd31,        32'h01F1_9113, 1'b0};
      vecs[11] = '{"sb_neg",    4'd6, 4'b0000, 1'b0, 5'd0, 5'd6, 5'd5, 32'hFFFF_FFFC, 32'hFE53_0E23, 1'b0};
      vecs[12] = '{"sra",       4'd2, 4'b1101, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h4031_50B3, 1'b0};
      vecs[13] = '{"addi_2048", 4'd1, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h8000_0093, RC};
      vecs[14] = '{"lui_low",   4'd9, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_1001, 32'h0000_10B7, RC};

      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_in(4'd0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst",  out_inst, 32'd0);
      chk("rst_out_addr",  out_addr, 32'd0);
      chk("rst_out_err",   32'(out_err), 32'd0);
      chk("rst_count",     32'(count), 32'd0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      reset_n = 1'b1;
      @(negedge clock);

      // Single-word table: push, check head one cycle later, pop.
      exp_addr = 32'h0;
      for (int i = 0; i < 15; i++) begin
         set_in(vecs[i].typ, vecs[i].alu, vecs[i].sgn, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].imm);
         in_valid = 1'b1;
         @(negedge clock);
         in_valid = 1'b0;
         chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
         chk({vecs[i].name, "_inst"},  out_inst, vecs[i].inst);
         chk({vecs[i].name, "_addr"},  out_addr, exp_addr);
         chk({vecs[i].name, "_err"},   32'(out_err), 32'(vecs[i].err));
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
         chk({vecs[i].name, "_drained"}, 32'(count), 32'd0);
         exp_addr = exp_addr + 32'd4;
      end

      // Pop while empty is ignored.
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk("empty_pop_count", 32'(count), 32'd0);
      chk("empty_pop_ready", 32'(in_ready), 32'd1);

      // Flush, then sub/sw back-to-back.
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      set_in(4'd2, 4'b1000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      in_valid = 1'b1;
      @(negedge clock);
      set_in(4'd8, 4'b0000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
      @(negedge clock);
      in_valid = 1'b0;
      chk("b2b_count", 32'(count), 32'd2);
      chk("b2b_sub_inst", out_inst, 32'h4020_81B3);
      chk("b2b_sub_addr", out_addr, 32'd0);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk("b2b_sw_inst", out_inst, 32'h0020_A423);
      chk("b2b_sw_addr", out_addr, 32'd4);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;

      // Fill while stalled: four accepted, fifth waits for space.
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         set_in(4'd1, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k));
         if (k < 5) @(negedge clock);
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_hold_inst", out_inst, 32'h0010_0093);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk("full_pop_count", 32'(count), 32'd3);
      chk("full_pop_head", out_addr, 32'd4);
      @(negedge clock);
      in_valid = 1'b0;
      chk("fifth_count", 32'(count), 32'd4);
      for (int k = 2; k <= 5; k++) begin
         chk("drain_inst", out_inst, (32'(k) << 20) | 32'h93);
         chk("drain_addr", out_addr, 32'((k - 1) * 4));
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
      end
      chk("drain_empty", 32'(out_valid), 32'd0);

      // Push+pop in one cycle with count in range keeps count.
      set_in(4'd1, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
      in_valid = 1'b1;
      @(negedge clock);
      out_ready = 1'b1;
      set_in(4'd1, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pushpop_count", 32'(count), 32'd1);
      chk("pushpop_inst", out_inst, 32'h0080_0093);
      chk("pushpop_addr", out_addr, 32'd24);

      // Flush with a same-cycle push: both dropped, address restarts.
      set_in(4'd1, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9);
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clock);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      chk("post_flush_addr", out_addr, 32'd0);
      chk("post_flush_inst", out_inst, 32'h0090_0093);

      // Asynchronous reset mid-transfer.
      in_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_addr",  out_addr, 32'd0);
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_count", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
